hex_scheduler: RTL

Sequences the six HEX seven-segment displays between two requesters: a persistent occupancy status (live car count plus a "FULL" banner) and transient event messages (for example, rush-hour results) accepted through a valid/ready handshake. Each accepted event is held for a fixed time, followed by a blank gap, and then the display returns to status. The block sits between the parking-lot control logic and the board HEX pins. It instantiates the team's `display` hex-to-segment decoder for numeric digits and muxes in letter and blank glyphs.

---
 rtl/hex_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hex_scheduler.sv
// Six-digit HEX display sequencer: lot occupancy status by default, with timed
// event messages (hold, then blank gap) taken over a valid/ready handshake.

module display (
    input  logic [3:0] value,
    output logic [6:0] segments
);
    always_comb begin
        case (value)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            default: segments = 7'b0001110;
        endcase
    end
endmodule

module hex_scheduler #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int CAPACITY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  count,
    input  logic        evt_valid,
    input  logic [23:0] evt_data,
    input  logic [5:0]  evt_blank,
    output logic        evt_ready,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [3:0] CAP = 4'(CAPACITY);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    typedef enum logic [1:0] {STATUS, EVENT, GAP} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [23:0]   data_q;
    logic [5:0]    blank_q;
    logic [3:0]    count_q;
    logic [3:0]    ones;
    logic [6:0]    ones_seg;
    logic [6:0]    evt_seg [6];
    logic [6:0]    hex_next [6];
    logic [6:0]    hex_q [6];
    logic          accept;

    // Handshake: a transfer happens on a rising edge where evt_valid and
    // evt_ready are both high and reset is low; evt_ready depends only on state.
    assign accept = evt_valid & evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATUS;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count;
        if (!reset && accept) begin
            data_q  <= evt_data;
            blank_q <= evt_blank;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            STATUS: if (accept) begin
                state_next = EVENT;
                timer_next = HOLD_LOAD;
            end
            EVENT: if (timer == '0) begin
                state_next = GAP;
                timer_next = GAP_LOAD;
            end else begin
                timer_next = timer - 1'b1;
            end
            GAP: if (timer == '0) begin
                state_next = STATUS;
            end else begin
                timer_next = timer - 1'b1;
            end
            default: state_next = STATUS;
        endcase
    end

    assign ones = (count_q >= 4'd10) ? count_q - 4'd10 : count_q;

    display u_ones (.value(ones), .segments(ones_seg));

    for (genvar i = 0; i < 6; i++) begin : g_evt
        display u_dig (.value(data_q[4*i +: 4]), .segments(evt_seg[i]));
    end

    always_comb begin
        evt_ready = (state == STATUS);
        busy      = (state != STATUS);
        for (int i = 0; i < 6; i++) hex_next[i] = SEG_BLANK;
        case (state)
            STATUS: begin
                hex_next[0] = ones_seg;
                if (count_q >= 4'd10) hex_next[1] = SEG_ONE;
                if (count_q >= CAP) begin
                    hex_next[2] = SEG_L;
                    hex_next[3] = SEG_L;
                    hex_next[4] = SEG_U;
                    hex_next[5] = SEG_F;
                end
            end
            EVENT: begin
                for (int i = 0; i < 6; i++)
                    if (!blank_q[i]) hex_next[i] = evt_seg[i];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (reset) hex_q[i] <= SEG_BLANK;
            else       hex_q[i] <= hex_next[i];
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
endmodule
